// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: datapath width, opcodes
// and the execute-stage state encoding.
package cpu_pkg;

    localparam int BITS = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;

    typedef enum logic [1:0] {
        EX_IDLE   = 2'd0,
        EX_EXEC   = 2'd1,
        EX_MEM    = 2'd2,
        EX_RETIRE = 2'd3
    } exec_state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage. Opcodes it does not handle pass
// the accumulator and flags through unchanged.
module exec_alu #(
    parameter int BITS = 8
) (
    input  logic [3:0]      opcode,
    input  logic [BITS-1:0] acc,
    input  logic [BITS-1:0] arg,
    input  logic            flag_z,
    input  logic            flag_c,
    output logic [BITS-1:0] result,
    output logic            z,
    output logic            c
);
    import cpu_pkg::*;

    logic [BITS:0] sum;
    logic [BITS:0] diff;
    logic          upd_z;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, arg};
        diff   = {1'b0, acc} - {1'b0, arg};
        result = acc;
        c      = flag_c;
        upd_z  = 1'b0;
        case (opcode)
            OP_LDI: begin result = arg;             upd_z = 1'b1; end
            OP_ADD: begin result = sum[BITS-1:0];   c = sum[BITS];  upd_z = 1'b1; end
            // The extra MSB of the widened difference is the borrow (arg > acc).
            OP_SUB: begin result = diff[BITS-1:0];  c = diff[BITS]; upd_z = 1'b1; end
            OP_AND: begin result = acc & arg;       upd_z = 1'b1; end
            OP_OR:  begin result = acc | arg;       upd_z = 1'b1; end
            OP_XOR: begin result = acc ^ arg;       upd_z = 1'b1; end
            default: ;
        endcase
        z = upd_z ? (result == '0) : flag_z;
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: accepts one decoded instruction at a time, owns acc/Z/C,
// runs load/store over a req/ack port with timeout, and reports branches.
module exec_unit #(
    parameter int BITS    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      opcode,
    input  logic [BITS-1:0] arg,
    output logic [BITS-1:0] acc,
    output logic            flag_z,
    output logic            flag_c,
    output logic            done,
    output logic            branch_taken,
    output logic [BITS-1:0] branch_target,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata,
    input  logic            mem_ack
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    exec_state_t     state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [BITS-1:0] arg_q, arg_d;
    logic [BITS-1:0] acc_q, acc_d;
    logic            z_q, z_d, c_q, c_d;
    logic            br_q, br_d, err_q, err_d;
    logic [BITS-1:0] tgt_q, tgt_d;
    logic            req_q, req_d, we_q, we_d;
    logic [BITS-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [BITS-1:0] alu_result;
    logic            alu_z, alu_c;
    logic            taken;

    exec_alu #(.BITS(BITS)) u_alu (
        .opcode (op_q),
        .acc    (acc_q),
        .arg    (arg_q),
        .flag_z (z_q),
        .flag_c (c_q),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_comb begin
        taken = 1'b0;
        case (op_q)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = z_q;
            OP_JC:   taken = c_q;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        br_d    = 1'b0;
        err_d   = 1'b0;
        tgt_d   = tgt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            EX_IDLE: begin
                if (in_valid) begin
                    op_d    = opcode;
                    arg_d   = arg;
                    state_d = EX_EXEC;
                end
            end
            EX_EXEC: begin
                state_d = EX_RETIRE;
                if (is_mem_op(op_q)) begin
                    req_d   = 1'b1;
                    addr_d  = arg_q;
                    we_d    = (op_q == OP_ST);
                    wdata_d = acc_q;
                    cnt_d   = '0;
                    state_d = EX_MEM;
                end else if (op_q > OP_JC) begin
                    err_d = 1'b1;
                end else begin
                    acc_d = alu_result;
                    z_d   = alu_z;
                    c_d   = alu_c;
                    br_d  = taken;
                    if (taken) tgt_d = arg_q;
                end
            end
            EX_MEM: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        acc_d = mem_rdata;
                        z_d   = (mem_rdata == '0);
                    end
                    req_d   = 1'b0;
                    state_d = EX_RETIRE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This edge is the TIMEOUT-th ack-less cycle: abandon the access.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = EX_RETIRE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EX_RETIRE: state_d = EX_IDLE;
            default:   state_d = EX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EX_IDLE;
            op_q    <= '0;
            arg_q   <= '0;
            acc_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            br_q    <= 1'b0;
            err_q   <= 1'b0;
            tgt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
            br_q    <= br_d;
            err_q   <= err_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready      = (state_q == EX_IDLE);
    assign done          = (state_q == EX_RETIRE);
    assign acc           = acc_q;
    assign flag_z        = z_q;
    assign flag_c        = c_q;
    assign branch_taken  = br_q;
    assign branch_target = tgt_q;
    assign err           = err_q;
    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: a driver pushes model predictions, a monitor
// checks each retirement, and a memory responder checks the memory port.
module tb_exec_unit;
    import cpu_pkg::*;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] arg;
    logic [7:0] acc;
    logic       flag_z, flag_c, done, branch_taken, err;
    logic [7:0] branch_target;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack, resp_ack, late_ack;

    assign mem_ack = resp_ack | late_ack;

    exec_unit #(.BITS(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .arg(arg), .acc(acc), .flag_z(flag_z), .flag_c(flag_c),
        .done(done), .branch_taken(branch_taken), .branch_target(branch_target),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] acc;
        logic       z, c, br, err;
        logic [7:0] tgt;
        int         lat;
        int         issue_cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;
    logic started = 1'b0;
    logic abort   = 1'b0;
    logic reset_test = 1'b0;

    // Reference state: architectural registers and a private copy of memory.
    logic [7:0] m_acc;
    logic       m_z, m_c;
    logic [7:0] model_mem [256];
    logic [7:0] dev_mem   [256];

    // What the memory port is expected to show for the current access.
    int         ack_delay = 0;
    int         exp_req_cycles = 0;
    logic [7:0] exp_addr, exp_wdata;
    logic       exp_we;

    logic [3:0] r_op;
    logic [7:0] r_arg;
    int         r_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input int dly);
        exp_t e;
        int   guard;
        int   s;
        guard = 0;
        if (abort) return;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                n_checks++;
                n_err++;
                $display("FAIL in_ready_wait: in_ready=%b after 200 cycles, expected 1", in_ready);
                abort = 1'b1;
                return;
            end
        end
        e.br  = 1'b0;
        e.err = 1'b0;
        e.tgt = 8'h00;
        e.lat = 2;
        case (op)
            OP_LDI: begin m_acc = a; m_z = (m_acc == 0); end
            OP_ADD: begin
                s = int'(m_acc) + int'(a);
                m_c = (s > 255);
                m_acc = 8'(s % 256);
                m_z = (m_acc == 0);
            end
            OP_SUB: begin
                m_c = (a > m_acc);
                s = int'(m_acc) - int'(a);
                if (s < 0) s = s + 256;
                m_acc = 8'(s);
                m_z = (m_acc == 0);
            end
            OP_AND: begin m_acc = m_acc & a; m_z = (m_acc == 0); end
            OP_OR:  begin m_acc = m_acc | a; m_z = (m_acc == 0); end
            OP_XOR: begin m_acc = m_acc ^ a; m_z = (m_acc == 0); end
            OP_LD, OP_ST: begin
                exp_addr  = a;
                exp_we    = (op == OP_ST);
                exp_wdata = m_acc;
                ack_delay = dly;
                if (dly >= 0) begin
                    e.lat = 3 + dly;
                    exp_req_cycles = dly + 1;
                    if (op == OP_LD) begin
                        m_acc = model_mem[a];
                        m_z = (m_acc == 0);
                    end else begin
                        model_mem[a] = m_acc;
                    end
                end else begin
                    e.lat = 2 + TIMEOUT;
                    exp_req_cycles = TIMEOUT;
                    e.err = 1'b1;
                end
            end
            OP_JMP: e.br = 1'b1;
            OP_JZ:  e.br = m_z;
            OP_JC:  e.br = m_c;
            OP_NOP: ;
            default: e.err = 1'b1;
        endcase
        if (e.br) e.tgt = a;
        e.acc = m_acc;
        e.z   = m_z;
        e.c   = m_c;
        e.issue_cyc = cyc;
        exp_q.push_back(e);
        opcode   = op;
        arg      = a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Memory device: acks after the requested number of wait cycles.
    int req_cycles = 0;
    initial begin
        resp_ack  = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            resp_ack  = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (!reset_test) begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                    chk("mem_we", 32'(mem_we), 32'(exp_we));
                    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                    if (ack_delay >= 0 && req_cycles == ack_delay + 1) begin
                        resp_ack = 1'b1;
                        if (mem_we) dev_mem[mem_addr] = mem_wdata;
                        else        mem_rdata = dev_mem[mem_addr];
                    end
                end
            end else if (req_cycles != 0) begin
                if (!reset_test) chk("mem_req_cycles", 32'(req_cycles), 32'(exp_req_cycles));
                req_cycles = 0;
            end
        end
    end

    // Monitor: every retirement is matched against the oldest prediction.
    logic ready_next = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (ready_next) chk("in_ready_after_done", 32'(in_ready), 32'd1);
                ready_next = 1'b0;
                if (done === 1'b1) begin
                    ready_next = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_done: done=1 with no instruction outstanding (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc", 32'(acc), 32'(e.acc));
                        chk("flag_z", 32'(flag_z), 32'(e.z));
                        chk("flag_c", 32'(flag_c), 32'(e.c));
                        chk("branch_taken", 32'(branch_taken), 32'(e.br));
                        if (e.br) chk("branch_target", 32'(branch_target), 32'(e.tgt));
                        chk("err", 32'(err), 32'(e.err));
                        chk("in_ready_during_done", 32'(in_ready), 32'd0);
                        chk("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
                    end
                end else begin
                    chk("pulse_without_done", 32'({branch_taken, err}), 32'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset    = 1'b1;
        in_valid = 1'b0;
        opcode   = 4'h0;
        arg      = 8'h00;
        late_ack = 1'b0;
        m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'($urandom);
            dev_mem[i]   = model_mem[i];
        end
        model_mem[8'h41] = 8'h00;
        dev_mem[8'h41]   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_c}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pulses", 32'({done, branch_taken, err}), 32'd0);
        chk("rst_branch_target", 32'(branch_target), 32'd0);
        chk("rst_mem", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'd0);
        started = 1'b1;

        issue(OP_LDI, 8'h00, 0);
        issue(OP_LDI, 8'hF0, 0);
        issue(OP_ADD, 8'h20, 0);
        issue(OP_SUB, 8'h11, 0);
        issue(OP_LDI, 8'h5A, 0);
        issue(OP_ST,  8'h40, 3);
        issue(OP_LD,  8'h41, 1);
        issue(OP_LD,  8'h40, 0);
        issue(OP_LD,  8'h10, -1);
        issue(OP_LDI, 8'h00, 0);
        issue(OP_JZ,  8'h33, 0);
        issue(OP_LDI, 8'h01, 0);
        issue(OP_JZ,  8'h33, 0);
        issue(4'hE,   8'hA5, 0);
        issue(OP_LDI, 8'hF0, 0);
        issue(OP_ADD, 8'h20, 0);
        issue(OP_JC,  8'h55, 0);
        issue(OP_SUB, 8'h05, 0);
        issue(OP_JC,  8'h55, 0);
        issue(OP_JMP, 8'h80, 0);
        issue(OP_XOR, 8'h0B, 0);
        issue(OP_ST,  8'h20, -1);
        issue(OP_LDI, 8'h99, 0);

        // Reset while a load is waiting on memory; a late ack must be ignored.
        guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
        reset_test = 1'b1;
        opcode   = OP_LD;
        arg      = 8'h77;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mem_req_before_reset", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        late_ack = 1'b1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_acc", 32'(acc), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_flags", 32'({flag_z, flag_c}), 32'd0);
        chk("mid_rst_mem_port", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
        @(negedge clk);
        late_ack = 1'b0;
        chk("late_ack_ignored_ready", 32'(in_ready), 32'd1);
        chk("late_ack_ignored_acc", 32'({acc, flag_z, flag_c, done}), 32'd0);
        m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0;
        reset_test = 1'b0;

        issue(OP_JZ,  8'h44, 0);
        issue(OP_ADD, 8'h00, 0);
        issue(OP_JZ,  8'h44, 0);

        for (int i = 0; i < 150; i++) begin
            r_op  = 4'($urandom_range(0, 15));
            r_arg = 8'($urandom);
            r_d   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            issue(r_op, r_arg, r_d);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin @(negedge clk); guard++; end
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage of the 8-bit accumulator CPU; sits directly downstream of the fetcher.
- Accepts one decoded instruction (4-bit opcode + 8-bit argument) over a valid/ready handshake.
- Owns the accumulator and Z/C flags, performs ALU ops, runs multi-cycle load/store over a req/ack memory port, and reports taken branches back to the fetcher for PC redirect.

Parameters:
- BITS, 8, datapath/accumulator/address width.
- TIMEOUT, 15, max cycles in MEM waiting for mem_ack before abort (must be >= 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- in_valid  in  1  fetcher presents an instruction.
- in_ready  out  1  unit can accept; high only in IDLE.
- opcode  in  4  instruction opcode.
- arg  in  BITS  immediate / memory address / branch target.
- acc  out  BITS  accumulator (registered).
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- done  out  1  one-cycle pulse: instruction retired.
- branch_taken  out  1  one-cycle pulse, coincident with done.
- branch_target  out  BITS  valid while branch_taken=1.
- err  out  1  one-cycle pulse, coincident with done: illegal opcode or memory timeout.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1=store, 0=load; valid with mem_req.
- mem_addr  out  BITS  memory address.
- mem_wdata  out  BITS  store data.
- mem_rdata  in  BITS  load data; valid when mem_ack=1.
- mem_ack  in  1  memory completion, one cycle.

Behaviour:
- Reset values: acc=0, flag_z=0, flag_c=0, state=IDLE, in_ready=1, done=0, branch_taken=0, branch_target=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- Reset in any state, including MEM with mem_req=1, returns everything to reset values on that edge. An in-flight ack is ignored.
- States: IDLE, EXEC, MEM, RETIRE.
- IDLE: in_ready=1. On an edge with in_valid=1, latch opcode/arg and go to EXEC. Otherwise stay in IDLE.
- EXEC: in_ready=0, one cycle.
  - Non-memory ops commit acc/flags on the exiting edge, then go to RETIRE.
  - LD/ST: on the exiting edge register mem_req=1, mem_addr=arg, mem_we=(ST), mem_wdata=acc; clear the counter; go to MEM.
- MEM: hold all mem_* outputs stable.
  - Edge with mem_ack=1: LD loads acc=mem_rdata and sets Z=(mem_rdata==0), C unchanged; ST leaves acc/flags unchanged. Drop mem_req and go to RETIRE.
  - Edge with mem_ack=0: counter+1. When the counter reaches TIMEOUT, drop mem_req, leave acc/flags unchanged, set err for the RETIRE cycle, and go to RETIRE.
  - mem_ack outside MEM is ignored.
- RETIRE: done=1 for exactly one cycle, plus branch_taken/err as applicable. Go to IDLE.
- Latency: ALU/branch op accepted at edge E0 gives acc valid after E1 and done high in the cycle E1–E2. Back-to-back throughput is 1 instruction per 3 cycles. LD/ST take 3 cycles + ack wait.
- Opcodes: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 LD, 8 ST, 9 JMP, A JZ, B JC, C–F illegal (retire with err=1, no other effect).
- Arithmetic:
  - ADD: {C,acc} = acc + arg, 9-bit; wraps modulo 2^BITS.
  - SUB: acc = acc − arg mod 2^BITS; C = 1 iff arg > acc (borrow).
  - AND/OR/XOR/LDI: Z updated, C unchanged. ADD/SUB update Z and C. Z = (new acc == 0).
- Branches:
  - JMP always taken.
  - JZ taken iff flag_z=1 at execute time; JC taken iff flag_c=1 at execute time.
  - When taken, branch_target=arg during RETIRE. When not taken, branch_taken=0 and done still pulses.
  - Branches never modify acc/flags.

Decomposition:
- Shared package cpu_pkg: BITS, opcode constants OP_NOP..OP_JC, exec state encoding. It sits alongside the existing STATE_*/FETCH_* constants.
- One natural sub-module: exec_alu (combinational: opcode, acc, arg, flags in; result, z, c out). FSM, memory port and timeout counter stay in exec_unit.

Test Plan:
- Reset, then LDI 0x00 → acc=0x00, Z=1, C=0, done pulses once 2 cycles after accept, in_ready high again the cycle after.
- LDI 0xF0; ADD 0x20 → acc=0x10, C=1, Z=0. Then SUB 0x11 → acc=0xFF, C=1 (borrow), Z=0.
- LDI 0x5A; ST 0x40 with ack after 3 cycles → mem_req high 4 cycles, mem_we=1, mem_addr=0x40, mem_wdata=0x5A. Then LD 0x41 with mem_rdata=0x00 → acc=0x00, Z=1.
- LD 0x10 with no ack (TIMEOUT=15) → mem_req drops after 15 wait cycles, err and done pulse together, acc unchanged.
- LDI 0; JZ 0x33 → branch_taken=1, branch_target=0x33 with done. Then LDI 1; JZ 0x33 → done=1, branch_taken=0. Opcode 0xE → err=1, acc unchanged.
- Assert reset while in MEM with mem_req=1 → next cycle mem_req=0, acc=0, in_ready=1; a late mem_ack is ignored.
